// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the requester-side handshakes (m0 = CPU data path, m1 = loader /
// debug port), the data-RAM command/response signals and the busy flag that
// dmem_arbiter drives.
//   slave  : arbiter view (requests and mem_rdata in; grants, dones, read data,
//            memory command and busy out)
//   master : environment view (requesters plus memory), directions reversed
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m1_req;
  logic              m0_we;
  logic              m1_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic              m0_gnt;
  logic              m1_gnt;
  logic              m0_done;
  logic              m1_done;
  logic [DATA_W-1:0] m0_rdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, mem_rdata,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
           m0_wdata, m1_wdata, mem_rdata,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter and sequencer for the single-port data RAM behind
// nanocpu. One access at a time: grant, one-cycle registered memory command,
// fixed MEM_LATENCY wait, then a one-cycle done pulse (with read data on a
// read) to the owning requester.
// Ports:
//   clock      rising-edge clock
//   not_reset  asynchronous active-low reset
//   bus        dmem_arbiter_if.slave: m0/m1 req/we/addr/wdata in,
//              m0/m1 gnt/done/rdata out, mem_en/we/addr/wdata out,
//              mem_rdata in, busy out
// Parameters: ADDR_W, DATA_W, MEM_LATENCY (1..15)
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
//   otherwise m0 has fixed priority on simultaneous requests.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clock,
  input  logic           not_reset,
  dmem_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;        // 0 = m0, 1 = m1
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_q;         // master served by the most recent grant
`endif

  logic grant_d;
  logic pick_m1_d;

  always_comb begin
    grant_d = bus.m0_req | bus.m1_req;
`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, m1 wins only if m0 was served last.
    pick_m1_d = bus.m1_req & (~bus.m0_req | ~last_q);
`else
    pick_m1_d = bus.m1_req & ~bus.m0_req;
`endif
  end

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          if (grant_d) begin
            owner_q     <= pick_m1_d;
            gnt0_q      <= ~pick_m1_d;
            gnt1_q      <= pick_m1_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= pick_m1_d ? bus.m1_we    : bus.m0_we;
            mem_addr_q  <= pick_m1_d ? bus.m1_addr  : bus.m0_addr;
            mem_wdata_q <= pick_m1_d ? bus.m1_wdata : bus.m0_wdata;
            cnt_q       <= CNT_W'(MEM_LATENCY);
            state_q     <= WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= pick_m1_d;
`endif
          end
        end
        WAIT: begin
          mem_en_q <= 1'b0;
          gnt0_q   <= 1'b0;
          gnt1_q   <= 1'b0;
          if (cnt_q == '0) begin
            // mem_rdata is valid in this cycle; mem_we_q still holds the
            // direction of the access in flight.
            state_q <= IDLE;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            if (!mem_we_q) begin
              if (owner_q) rdata1_q <= bus.mem_rdata;
              else         rdata0_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_gnt    = gnt0_q;
  assign bus.m1_gnt    = gnt1_q;
  assign bus.m0_done   = done0_q;
  assign bus.m1_done   = done1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q == WAIT);

endmodule

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter
// Three arbiter instances (MEM_LATENCY 1, 3, 15) driven by directed requests.
// A cycle-indexed schedule model predicts every output of every instance from
// the timing rules; literal pins fix the key cycles by hand.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int NL = 3;
  localparam int NC = 512;

  localparam int S_GNT0 = 0, S_GNT1 = 1, S_DONE0 = 2, S_DONE1 = 3, S_EN = 4,
                 S_WE = 5, S_ADDR = 6, S_WDATA = 7, S_RD0 = 8, S_RD1 = 9,
                 S_BUSY = 10, NSIG = 11;

  logic clock = 1'b0;
  logic not_reset = 1'b0;
  int   cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic [NL-1:0]        i_req0, i_req1, i_we0, i_we1;
  logic [NL-1:0][31:0]  i_addr0, i_addr1, i_wd0, i_wd1, i_mrd;
  logic [NL-1:0]        o_gnt0, o_gnt1, o_done0, o_done1, o_en, o_we, o_busy;
  logic [NL-1:0][31:0]  o_addr, o_wdata, o_rd0, o_rd1;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    localparam int L = (k == 0) ? 1 : (k == 1) ? 3 : 15;
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    assign bus.m0_req    = i_req0[k];
    assign bus.m1_req    = i_req1[k];
    assign bus.m0_we     = i_we0[k];
    assign bus.m1_we     = i_we1[k];
    assign bus.m0_addr   = i_addr0[k];
    assign bus.m1_addr   = i_addr1[k];
    assign bus.m0_wdata  = i_wd0[k];
    assign bus.m1_wdata  = i_wd1[k];
    assign bus.mem_rdata = i_mrd[k];
    assign o_gnt0[k]  = bus.m0_gnt;
    assign o_gnt1[k]  = bus.m1_gnt;
    assign o_done0[k] = bus.m0_done;
    assign o_done1[k] = bus.m1_done;
    assign o_rd0[k]   = bus.m0_rdata;
    assign o_rd1[k]   = bus.m1_rdata;
    assign o_en[k]    = bus.mem_en;
    assign o_we[k]    = bus.mem_we;
    assign o_addr[k]  = bus.mem_addr;
    assign o_wdata[k] = bus.mem_wdata;
    assign o_busy[k]  = bus.busy;
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L)) u_dut (
      .clock    (clock),
      .not_reset(not_reset),
      .bus      (bus)
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 15;
  endfunction

  // ---------------- schedule model: expectations indexed by cycle ----------
  bit          e_gnt0 [NL][NC];
  bit          e_gnt1 [NL][NC];
  bit          e_done0[NL][NC];
  bit          e_done1[NL][NC];
  bit          e_en   [NL][NC];
  bit          e_busy [NL][NC];
  bit          e_we   [NL][NC];
  logic [31:0] e_addr [NL][NC];
  logic [31:0] e_wd   [NL][NC];
  bit          smp_v  [NL][NC];   // mem_rdata must be captured this cycle
  bit          smp_o  [NL][NC];
  bit          upd_v  [NL][NC];   // rdata changes to upd_val this cycle
  bit          upd_o  [NL][NC];
  logic [31:0] upd_val[NL][NC];
  logic [31:0] cur_rd0[NL];
  logic [31:0] cur_rd1[NL];
  int          free_at[NL];
  bit          last_m [NL];

  typedef struct {
    int          lane;
    int          c;
    int          sig;
    logic [31:0] val;
  } pin_t;
  pin_t pins[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic string sig_name(input int s);
    case (s)
      S_GNT0:  return "m0_gnt";
      S_GNT1:  return "m1_gnt";
      S_DONE0: return "m0_done";
      S_DONE1: return "m1_done";
      S_EN:    return "mem_en";
      S_WE:    return "mem_we";
      S_ADDR:  return "mem_addr";
      S_WDATA: return "mem_wdata";
      S_RD0:   return "m0_rdata";
      S_RD1:   return "m1_rdata";
      default: return "busy";
    endcase
  endfunction

  function automatic logic [31:0] out_of(input int k, input int s);
    case (s)
      S_GNT0:  return 32'(o_gnt0[k]);
      S_GNT1:  return 32'(o_gnt1[k]);
      S_DONE0: return 32'(o_done0[k]);
      S_DONE1: return 32'(o_done1[k]);
      S_EN:    return 32'(o_en[k]);
      S_WE:    return 32'(o_we[k]);
      S_ADDR:  return o_addr[k];
      S_WDATA: return o_wdata[k];
      S_RD0:   return o_rd0[k];
      S_RD1:   return o_rd1[k];
      default: return 32'(o_busy[k]);
    endcase
  endfunction

  function automatic logic [31:0] exp_of(input int k, input int x, input int s);
    case (s)
      S_GNT0:  return 32'(e_gnt0[k][x]);
      S_GNT1:  return 32'(e_gnt1[k][x]);
      S_DONE0: return 32'(e_done0[k][x]);
      S_DONE1: return 32'(e_done1[k][x]);
      S_EN:    return 32'(e_en[k][x]);
      S_WE:    return 32'(e_we[k][x]);
      S_ADDR:  return e_addr[k][x];
      S_WDATA: return e_wd[k][x];
      S_RD0:   return cur_rd0[k];
      S_RD1:   return cur_rd1[k];
      default: return 32'(e_busy[k][x]);
    endcase
  endfunction

  task automatic chk(input int k, input int x, input int s,
                     input logic [31:0] got, input logic [31:0] exp,
                     input bit is_pin);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s lane%0d cycle%0d %s: got %h, expected %h",
               is_pin ? "pin" : "model", k, x, sig_name(s), got, exp);
    end
  endtask

  always @(negedge clock) begin : compare
    int x;
    int lat;
    int w;
    x = cyc;
    if (x < NC - 20) begin
      for (int k = 0; k < NL; k++) begin
        lat = lat_of(k);
        if (!not_reset) begin
          for (int i = x; i < NC; i++) begin
            e_gnt0[k][i] = 0; e_gnt1[k][i] = 0; e_done0[k][i] = 0;
            e_done1[k][i] = 0; e_en[k][i] = 0; e_busy[k][i] = 0;
            smp_v[k][i] = 0; upd_v[k][i] = 0;
          end
          cur_rd0[k] = '0;
          cur_rd1[k] = '0;
          free_at[k] = x + 1;
          last_m[k]  = 1'b1;
        end else if (upd_v[k][x]) begin
          if (upd_o[k][x]) cur_rd1[k] = upd_val[k][x];
          else             cur_rd0[k] = upd_val[k][x];
        end

        for (int s = 0; s < NSIG; s++) begin
          // command fields only mean something while mem_en is expected
          if (!((s == S_WE || s == S_ADDR || s == S_WDATA) && !e_en[k][x]))
            chk(k, x, s, out_of(k, s), exp_of(k, x, s), 1'b0);
        end
        foreach (pins[i]) begin
          if (pins[i].lane == k && pins[i].c == x)
            chk(k, x, pins[i].sig, out_of(k, pins[i].sig), pins[i].val, 1'b1);
        end

        if (not_reset) begin
          if (smp_v[k][x]) begin
            upd_v[k][x+1]   = 1'b1;
            upd_o[k][x+1]   = smp_o[k][x];
            upd_val[k][x+1] = i_mrd[k];
          end
          if (x >= free_at[k] && (i_req0[k] || i_req1[k])) begin
            if (i_req0[k] && i_req1[k]) begin
`ifdef ARB_ROUND_ROBIN_EN
              w = last_m[k] ? 0 : 1;
`else
              w = 0;
`endif
            end else begin
              w = i_req1[k] ? 1 : 0;
            end
            last_m[k] = (w == 1);
            if (w == 1) e_gnt1[k][x+1] = 1'b1;
            else        e_gnt0[k][x+1] = 1'b1;
            e_en[k][x+1]   = 1'b1;
            e_we[k][x+1]   = (w == 1) ? i_we1[k]   : i_we0[k];
            e_addr[k][x+1] = (w == 1) ? i_addr1[k] : i_addr0[k];
            e_wd[k][x+1]   = (w == 1) ? i_wd1[k]   : i_wd0[k];
            for (int i = x + 1; i <= x + 1 + lat; i++) e_busy[k][i] = 1'b1;
            if (!e_we[k][x+1]) begin
              smp_v[k][x+1+lat] = 1'b1;
              smp_o[k][x+1+lat] = (w == 1);
            end
            if (w == 1) e_done1[k][x+2+lat] = 1'b1;
            else        e_done0[k][x+2+lat] = 1'b1;
            free_at[k] = x + 2 + lat;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic pin(input int k, input int c, input int s, input logic [31:0] v);
    pin_t p;
    p.lane = k; p.c = c; p.sig = s; p.val = v;
    pins.push_back(p);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents a one-shot request in the current cycle t; the arbiter is idle,
  // so the request is dropped again once the grant cycle has started.
  task automatic issue(input int k, input bit m, input bit we,
                       input logic [31:0] a, input logic [31:0] wd,
                       output int t);
    if (!m) begin
      i_req0[k] = 1'b1; i_we0[k] = we; i_addr0[k] = a; i_wd0[k] = wd;
    end else begin
      i_req1[k] = 1'b1; i_we1[k] = we; i_addr1[k] = a; i_wd1[k] = wd;
    end
    t = cyc;
    wait_cyc(1);
    if (!m) i_req0[k] = 1'b0;
    else    i_req1[k] = 1'b0;
  endtask

  initial begin : stim
    int t;
    i_req0 = '0; i_req1 = '0; i_we0 = '0; i_we1 = '0;
    i_addr0 = '0; i_addr1 = '0; i_wd0 = '0; i_wd1 = '0; i_mrd = '0;
    not_reset = 1'b0;
    pin(0, 2, S_BUSY, 32'h0);
    pin(0, 2, S_EN,   32'h0);
    pin(0, 2, S_RD0,  32'h0);
    wait_cyc(3);
    not_reset = 1'b1;

    // m0 read, latency 1
    i_mrd[0] = 32'hDEADBEEF;
    issue(0, 1'b0, 1'b0, 32'h10, 32'h0, t);
    pin(0, t+1, S_GNT0, 32'h1);
    pin(0, t+1, S_EN,   32'h1);
    pin(0, t+1, S_ADDR, 32'h10);
    pin(0, t+1, S_GNT1, 32'h0);
    pin(0, t+2, S_DONE0, 32'h0);
    pin(0, t+3, S_DONE0, 32'h1);
    pin(0, t+3, S_RD0,  32'hDEADBEEF);
    pin(0, t+3, S_DONE1, 32'h0);
    pin(0, t+3, S_RD1,  32'h0);
    wait_cyc(4);

    // m1 read then m1 write: write must leave m1_rdata alone
    i_mrd[0] = 32'h0BADF00D;
    issue(0, 1'b1, 1'b0, 32'h24, 32'h0, t);
    pin(0, t+3, S_RD1, 32'h0BADF00D);
    wait_cyc(4);
    i_mrd[0] = 32'hFFFFFFFF;
    issue(0, 1'b1, 1'b1, 32'h20, 32'h12345678, t);
    pin(0, t+1, S_EN,    32'h1);
    pin(0, t+1, S_WE,    32'h1);
    pin(0, t+1, S_ADDR,  32'h20);
    pin(0, t+1, S_WDATA, 32'h12345678);
    pin(0, t+2, S_EN,    32'h0);
    pin(0, t+2, S_DONE1, 32'h0);
    pin(0, t+3, S_DONE1, 32'h1);
    pin(0, t+3, S_RD1,   32'h0BADF00D);
    pin(0, t+3, S_RD0,   32'hDEADBEEF);
    wait_cyc(4);

    // m1 requests while m0 is in flight
    i_mrd[0] = 32'h600DCAFE;
    issue(0, 1'b0, 1'b0, 32'h30, 32'h0, t);
    i_req1[0] = 1'b1; i_we1[0] = 1'b0; i_addr1[0] = 32'h40;
    pin(0, t+1, S_BUSY, 32'h1);
    pin(0, t+2, S_BUSY, 32'h1);
    pin(0, t+2, S_GNT1, 32'h0);
    pin(0, t+3, S_GNT1, 32'h0);
    pin(0, t+3, S_DONE0, 32'h1);
    pin(0, t+3, S_BUSY, 32'h0);
    pin(0, t+4, S_GNT1, 32'h1);
    pin(0, t+4, S_ADDR, 32'h40);
    wait_cyc(3);
    i_req1[0] = 1'b0;
    wait_cyc(4);

    // latency 15: mem_rdata changes every cycle to pin the capture cycle
    i_mrd[2] = 32'h0;
    issue(2, 1'b0, 1'b0, 32'h50, 32'h0, t);
    pin(2, t+16, S_DONE0, 32'h0);
    pin(2, t+16, S_BUSY,  32'h1);
    pin(2, t+17, S_DONE0, 32'h1);
    pin(2, t+17, S_BUSY,  32'h0);
    pin(2, t+17, S_RD0,   32'hA5000000 | 32'(t + 16));
    repeat (20) begin
      i_mrd[2] = 32'hA5000000 | 32'(cyc);
      wait_cyc(1);
    end

    // continuous requests from both masters, latency 3
    i_mrd[1] = 32'h11112222;
    i_req0[1] = 1'b1; i_we0[1] = 1'b0; i_addr0[1] = 32'h100;
    i_req1[1] = 1'b1; i_we1[1] = 1'b0; i_addr1[1] = 32'h200;
    t = cyc;
    pin(1, t+1, S_GNT0, 32'h1);
    pin(1, t+1, S_ADDR, 32'h100);
    pin(1, t+11, S_GNT0, 32'h1);
`ifdef ARB_ROUND_ROBIN_EN
    pin(1, t+6,  S_GNT1, 32'h1);
    pin(1, t+6,  S_ADDR, 32'h200);
    pin(1, t+16, S_GNT1, 32'h1);
`else
    pin(1, t+6,  S_GNT0, 32'h1);
    pin(1, t+6,  S_GNT1, 32'h0);
    pin(1, t+6,  S_ADDR, 32'h100);
    pin(1, t+16, S_GNT0, 32'h1);
`endif
    wait_cyc(22);
    i_req0[1] = 1'b0;
    i_req1[1] = 1'b0;
    wait_cyc(8);

    // asynchronous reset in the middle of a latency-1 access
    i_mrd[0] = 32'h77778888;
    issue(0, 1'b0, 1'b0, 32'h60, 32'h0, t);
    #1;
    not_reset = 1'b0;
    pin(0, t+1, S_EN,    32'h0);
    pin(0, t+1, S_BUSY,  32'h0);
    pin(0, t+1, S_GNT0,  32'h0);
    pin(0, t+1, S_RD0,   32'h0);
    pin(0, t+1, S_RD1,   32'h0);
    pin(0, t+2, S_DONE0, 32'h0);
    pin(0, t+3, S_DONE0, 32'h0);
    wait_cyc(2);
    not_reset = 1'b1;
    i_mrd[0] = 32'h13579BDF;
    issue(0, 1'b0, 1'b0, 32'h70, 32'h0, t);
    pin(0, t+1, S_GNT0,  32'h1);
    pin(0, t+3, S_DONE0, 32'h1);
    pin(0, t+3, S_RD0,   32'h13579BDF);
    wait_cyc(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter and sequencer for the single-port data memory behind nanocpu.
- Port m0 serves the CPU data path; port m1 serves the program loader/debug port.
- Accepts one transaction at a time, drives a registered memory command, waits a fixed memory latency, then returns read data with a one-cycle done pulse to the owning requester.
- Sits between the CPU/loader and the data RAM.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
- clock  in  1  rising-edge clock
- not_reset  in  1  asynchronous, active-low reset
- m0_req, m1_req  in  1  request; held until grant
- m0_we, m1_we  in  1  1 = write, 0 = read; held with req
- m0_addr, m1_addr  in  ADDR_W  address; held with req
- m0_wdata, m1_wdata  in  DATA_W  write data; held with req
- m0_gnt, m1_gnt  out  1  one-cycle pulse: request accepted
- m0_done, m1_done  out  1  one-cycle pulse: access complete
- m0_rdata, m1_rdata  out  DATA_W  read data; valid with done
- mem_en  out  1  memory command strobe; one cycle per access
- mem_we  out  1  memory write enable; qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state WAIT)

## Operation
- States:
  - IDLE: requests are sampled only in this state.
  - WAIT: a transaction is in flight.
- IDLE, no request: stay in IDLE; all pulses 0.
- IDLE, one request: grant that requester at the clock edge.
- IDLE, both requests: tie-break per Configuration.
- At the grant edge:
  - latch the owner;
  - register mem_addr, mem_we, mem_wdata from the owner;
  - set mem_en=1 and owner gnt=1;
  - load cnt=MEM_LATENCY;
  - go to WAIT.
- WAIT: mem_en and gnt drop after the first WAIT cycle; cnt decrements each cycle; busy=1.
- WAIT with cnt==0 (mem_rdata valid this cycle), at the edge:
  - go to IDLE;
  - owner done=1;
  - on a read, owner rdata<=mem_rdata.
- A write also produces done; rdata is unchanged on a write.
- Each mN_rdata holds its last read value until that master's next read done.
- The non-owner's outputs never pulse.
- Requests arriving during WAIT are not sampled; they wait for IDLE.
- A requester that keeps req high after gnt is treated as issuing a new request in the next IDLE cycle.
- The arbiter passes addresses through unmodified: no alignment checks, no transformation.

## Timing
- Edge E0 ends IDLE cycle T in which req is seen.
  - Cycle T+1: gnt=1, mem_en=1, busy=1.
  - Cycle T+1+MEM_LATENCY: mem_rdata sampled.
  - Cycle T+2+MEM_LATENCY: done=1, rdata valid; state is IDLE.
- A new grant can issue at the edge ending cycle T+2+MEM_LATENCY.
- Maximum throughput: one access per MEM_LATENCY+2 cycles.
- All outputs are registered; no combinational path from any input to any output.
- Reset (async, not_reset=0) takes effect immediately, without waiting for a clock edge:
  - state=IDLE, cnt=0;
  - every output = 0, including mem_en and both rdata buses;
  - round-robin pointer last=1.
- Reset mid-WAIT abandons the access with no done pulse.
- After not_reset rises, the first grant occurs at the first clock edge.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - on simultaneous requests, grant the master not served last;
  - register `last` updates at every grant;
  - reset value last=1, so m0 wins the first tie.
- ARB_ROUND_ROBIN_EN undefined:
  - fixed priority, m0 always wins ties;
  - no `last` register;
  - m1 can starve under continuous m0 traffic.

## Test plan
- Read, MEM_LATENCY=1. m0_req, read, addr=0x10, memory returns 0xDEADBEEF:
  - m0_gnt and mem_en in cycle T+1 with mem_addr=0x10;
  - m0_done in T+3 with m0_rdata=0xDEADBEEF;
  - m1 outputs stay 0.
- Write. m1 write addr=0x20, wdata=0x12345678:
  - mem_en=1, mem_we=1, mem_wdata=0x12345678 for exactly one cycle;
  - m1_done pulses 1+MEM_LATENCY cycles later;
  - m1_rdata unchanged.
- Simultaneous requests. m0 and m1 both request continuously, MEM_LATENCY=3:
  - with ARB_ROUND_ROBIN_EN, grants alternate m0,m1,m0,m1 at a 5-cycle period;
  - without it, every grant goes to m0.
- Request during WAIT. m1_req rises while m0 is in flight:
  - m1 is not granted until the edge after m0_done's cycle;
  - busy stays 1 throughout m0's WAIT.
- Reset mid-operation. not_reset=0 between clock edges during WAIT:
  - mem_en, busy, gnt, done and rdata go to 0 immediately;
  - no done pulse follows;
  - after release, a fresh m0 read completes normally.
- Latency sweep. MEM_LATENCY=15 read:
  - done arrives exactly 17 cycles after the request-sampling cycle;
  - rdata equals the mem_rdata value in cycle T+16.
